catch_turn_controller: RTL

- Rally/turn sequencer for the two-glove catch game; sits beside the ball state machine.
- Watches ball_state, catch/throw events and ball height; drives per-glove catch permission (can_catch1/can_catch2) and the serve request wired to the ball SM reset input.
- Detects drops and flight timeouts, keeps per-player score and rally length, declares game over.

---
 rtl/catch_turn_controller.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/catch_turn_controller.sv
// Rally/turn sequencer for the two-glove catch game: serve, catch permission, drops, scoring, game over.
// Optional SELF_CATCH_EN lets the thrower re-catch its own ball after SELF_MIN_TICKS ticks of flight.
module catch_turn_controller #(
   parameter int WIN_SCORE      = 11,
   parameter int FLOOR_MM       = 60,
   parameter int FLIGHT_TIMEOUT = 512,
   parameter int PAUSE_TICKS    = 128,
   parameter int SELF_MIN_TICKS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        start,
   input  logic [1:0]  ball_state,
   input  logic        catch_event,
   input  logic        throw_event,
   input  logic [15:0] ball_y,
   output logic        can_catch1,
   output logic        can_catch2,
   output logic        serve_req,
   output logic [7:0]  score1,
   output logic [7:0]  score2,
   output logic [7:0]  rally_count,
   output logic [2:0]  game_state,
   output logic        game_over,
   output logic [1:0]  winner
);
   // state   | meaning
   // IDLE    | waiting for the first start edge
   // SERVE   | serve_req high, waiting for a glove to hold the ball
   // HELD    | a glove holds the ball, waiting for the throw
   // FLIGHT  | ball airborne, receiver may catch
   // DROPPED | point awarded to thrower, pause before next serve
   // OVER    | a player reached WIN_SCORE, waiting for start
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SERVE   = 3'd1;
   localparam logic [2:0] S_HELD    = 3'd2;
   localparam logic [2:0] S_FLIGHT  = 3'd3;
   localparam logic [2:0] S_DROPPED = 3'd4;
   localparam logic [2:0] S_OVER    = 3'd5;

   localparam logic [7:0]  WIN   = 8'(WIN_SCORE);
   localparam logic [15:0] FLOOR = 16'(FLOOR_MM);
   localparam logic [9:0]  FT    = 10'(FLIGHT_TIMEOUT);
   localparam logic [7:0]  PT    = 8'(PAUSE_TICKS);
   localparam logic [9:0]  SMIN  = 10'(SELF_MIN_TICKS);
`ifdef SELF_CATCH_EN
   localparam bit SELF_EN = 1'b1;
`else
   localparam bit SELF_EN = 1'b0;
`endif

   logic [2:0] state_q, state_n;
   logic [1:0] holder_q, holder_n, thrower_q, thrower_n, winner_n;
   logic [9:0] flight_q, flight_n;
   logic [7:0] pause_q, pause_n, score1_n, score2_n, rally_n;
   logic       start_q, catch_q, throw_q;
   logic       start_e, catch_e, throw_e;
   logic [1:0] bs, rcv, rcv_n;
   logic       self_ok_n;

   assign start_e = start & ~start_q;
   assign catch_e = catch_event & ~catch_q;
   assign throw_e = throw_event & ~throw_q;
   assign bs      = (ball_state == 2'd3) ? 2'd0 : ball_state;
   assign rcv     = (thrower_q == 2'd1) ? 2'd2 : 2'd1;
   assign game_state = state_q;

   always_comb begin
      state_n   = state_q;
      holder_n  = holder_q;
      thrower_n = thrower_q;
      flight_n  = flight_q;
      pause_n   = pause_q;
      score1_n  = score1;
      score2_n  = score2;
      rally_n   = rally_count;
      winner_n  = winner;
      case (state_q)
         S_IDLE: if (start_e) begin
            state_n  = S_SERVE;
            score1_n = '0;
            score2_n = '0;
            rally_n  = '0;
         end
         S_SERVE: if (bs != 2'd0) begin
            state_n  = S_HELD;
            holder_n = bs;
            rally_n  = '0;
         end
         S_HELD: if (throw_e || bs == 2'd0) begin
            state_n   = S_FLIGHT;
            thrower_n = holder_q;
            flight_n  = '0;
         end
         S_FLIGHT: begin
            if (tick && flight_q < FT) flight_n = flight_q + 10'd1;
            if (catch_e && bs == rcv) begin
               state_n  = S_HELD;
               holder_n = rcv;
               if (rally_count != 8'hFF) rally_n = rally_count + 8'd1;
            end else if (SELF_EN && catch_e && bs == thrower_q && flight_q >= SMIN) begin
               state_n  = S_HELD;
               holder_n = thrower_q;
            end else if ((tick && ball_y <= FLOOR) || flight_q >= FT) begin
               state_n = S_DROPPED;
               pause_n = '0;
               if (thrower_q == 2'd1) begin
                  if (score1 != 8'hFF) score1_n = score1 + 8'd1;
               end else begin
                  if (score2 != 8'hFF) score2_n = score2 + 8'd1;
               end
            end
         end
         S_DROPPED: begin
            if (tick && pause_q < PT) pause_n = pause_q + 8'd1;
            if (pause_q >= PT) begin
               if (((thrower_q == 2'd1) ? score1 : score2) >= WIN) begin
                  state_n  = S_OVER;
                  winner_n = thrower_q;
               end else begin
                  state_n = S_SERVE;
               end
            end
         end
         S_OVER: if (start_e) begin
            state_n  = S_SERVE;
            score1_n = '0;
            score2_n = '0;
            rally_n  = '0;
            winner_n = '0;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Permission outputs are decoded from next-state values so they stay registered yet cycle-aligned with game_state.
   assign rcv_n     = (thrower_n == 2'd1) ? 2'd2 : 2'd1;
   assign self_ok_n = SELF_EN && (flight_n >= SMIN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         holder_q    <= '0;
         thrower_q   <= '0;
         flight_q    <= '0;
         pause_q     <= '0;
         start_q     <= 1'b0;
         catch_q     <= 1'b0;
         throw_q     <= 1'b0;
         score1      <= '0;
         score2      <= '0;
         rally_count <= '0;
         winner      <= '0;
         can_catch1  <= 1'b0;
         can_catch2  <= 1'b0;
         serve_req   <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         state_q     <= state_n;
         holder_q    <= holder_n;
         thrower_q   <= thrower_n;
         flight_q    <= flight_n;
         pause_q     <= pause_n;
         start_q     <= start;
         catch_q     <= catch_event;
         throw_q     <= throw_event;
         score1      <= score1_n;
         score2      <= score2_n;
         rally_count <= rally_n;
         winner      <= winner_n;
         can_catch1  <= (state_n == S_FLIGHT) &&
                        (rcv_n == 2'd1 || (self_ok_n && thrower_n == 2'd1));
         can_catch2  <= (state_n == S_FLIGHT) &&
                        (rcv_n == 2'd2 || (self_ok_n && thrower_n == 2'd2));
         serve_req   <= (state_n == S_SERVE);
         game_over   <= (state_n == S_OVER);
      end
   end
endmodule
